apb_master_nsel: RTL
====================

Name: apb_master_nsel

Overview:
Parametrised APB master bridge. It converts a valid/ready command port into APB3/APB4 transfers toward NUM_SLV slaves, decoding each slave select from the upper address bits. It is the successor of the fixed-width single-slave master/slave top. New capabilities: configurable address and data widths, byte strobes, multi-slave decode, PSLVERR propagation, and a wait-state timeout. It sits between the system command source and the peripheral APB fabric.

Parameters:
ADDR_W, 16, address width; must be at least $clog2(NUM_SLV)+2
DATA_W, 32, data width; must be 8, 16 or 32
NUM_SLV, 4, number of slaves (1..8); slave index = cmd_addr_i[ADDR_W-1 -: SEL_W], where SEL_W = max(1, $clog2(NUM_SLV))
TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
pclk  in  1  APB clock; all logic is rising-edge
preset_n  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when cmd_valid_i && cmd_ready_o
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_W  byte address
cmd_wdata_i  in  DATA_W  write data
cmd_strb_i  in  DATA_W/8  write byte strobes
rsp_valid_o  out  1  one-cycle response pulse
rsp_rdata_o  out  DATA_W  read data; 0 for writes and for errors
rsp_err_o  out  2  00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT
paddr_o  out  ADDR_W  APB address
psel_o  out  NUM_SLV  one-hot select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_W  APB write data
pstrb_o  out  DATA_W/8  APB strobes; all 0 on reads
pready_i  in  NUM_SLV  per-slave PREADY
prdata_i  in  NUM_SLV*DATA_W  per-slave PRDATA, slave k at bits [k*DATA_W +: DATA_W]
pslverr_i  in  NUM_SLV  per-slave PSLVERR

Behaviour:
- Reset (asynchronous, preset_n=0):
  - all outputs 0 except cmd_ready_o=1
  - state = IDLE, timeout counter = 0
  - an in-flight transfer is dropped; no response is issued
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o=1
  - on accept, latch addr/wdata/strb/write
  - slave index < NUM_SLV -> SETUP
  - slave index >= NUM_SLV -> RESP with DECERR; no psel is asserted
- SETUP (exactly one cycle):
  - psel_o[idx]=1, penable_o=0, paddr/pwrite/pwdata/pstrb valid
  - -> ACCESS
- ACCESS:
  - psel held, penable_o=1, all APB outputs stable
  - pready_i[idx]=1: capture prdata_i[idx] (reads only) and pslverr_i[idx] -> RESP
  - otherwise increment the timeout counter
  - counter reaches TIMEOUT (TIMEOUT>0): -> RESP with TIMEOUT, rdata 0
  - pready_i and timeout in the same cycle: pready wins
- RESP:
  - psel_o=0, penable_o=0
  - rsp_valid_o=1 for exactly one cycle; the response source must accept it (no backpressure)
  - -> IDLE
- cmd_ready_o=0 in SETUP, ACCESS and RESP.
- Latency, zero wait states: accept at edge T, SETUP in T+1, ACCESS in T+2, rsp_valid_o in T+3.
  - Each wait state adds 1 cycle.
  - Back-to-back accept is possible in the cycle after RESP; sustained throughput is 1 transfer per 4 cycles.
- SLVERR read returns rdata 0, err 01.
- pready_i and pslverr_i of unselected slaves are ignored.
- Timeout counter clears on every SETUP entry; its width is $clog2(TIMEOUT+1).
- APB outputs return to 0 in IDLE (paddr/pwdata may be held; the bench must not check them while psel_o=0).

Decomposition:
- apb_pkg: apb_state_e {IDLE, SETUP, ACCESS, RESP}, apb_err_e {ERR_OKAY, ERR_SLV, ERR_DEC, ERR_TIMEOUT}.
- Sub-module apb_addr_decode: combinational address -> one-hot select plus decode-error flag, parametrised by ADDR_W/NUM_SLV.
- The FSM, latches and timeout counter stay in apb_master_nsel.

Test Plan:
1. Defaults. Write addr 0x4010, data 0x1234ABCD, strb 0xF, slave 1 pready tied 1:
   - psel_o=0010 for 2 cycles, penable only in the 2nd, pwdata=0x1234ABCD
   - rsp_valid at T+3, err 00
2. Read addr 0x8004. Slave 2 returns 0x5678EF01 after 3 wait states:
   - rsp_valid at T+6, rdata 0x5678EF01, err 00
   - APB outputs stable throughout ACCESS
3. NUM_SLV=3. Read addr 0xC000 (index 3):
   - no psel asserted
   - rsp_valid at T+1 with err 10, rdata 0
4. TIMEOUT=16. Slave 0 never asserts pready:
   - exactly 16 ACCESS cycles
   - rsp err 11, rdata 0
   - next command accepted in the following cycle
5. Read with pslverr_i[1]=1 and pready:
   - err 01, rdata 0
   - unselected slave 3 driving pslverr=1 does not affect a concurrent transfer to slave 0
6. Assert preset_n=0 mid-ACCESS:
   - psel/penable/rsp_valid drop to 0 asynchronously, no response
   - after release, cmd_ready_o=1 and a fresh write completes normally

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg : shared state/error encodings for the multi-slave APB master
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_OKAY    = 2'b00,
    ERR_SLV     = 2'b01,
    ERR_DEC     = 2'b10,
    ERR_TIMEOUT = 2'b11
  } apb_err_e;

  // Slave-index field width; a single slave still gets one decode bit.
  function automatic int sel_width(input int num_slv);
    return (num_slv > 1) ? $clog2(num_slv) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_addr_decode : upper address bits -> one-hot slave select + decode error
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int NUM_SLV = 4
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV-1:0] sel,
  output logic               dec_err
);

  localparam int SEL_W = sel_width(NUM_SLV);

  logic [SEL_W-1:0] idx;

  assign idx = addr[ADDR_W-1 -: SEL_W];

  // Indices past the last slave match nothing and flag a decode error.
  always_comb begin
    sel     = '0;
    dec_err = 1'b1;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (idx == SEL_W'(k)) begin
        sel[k]  = 1'b1;
        dec_err = 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_nsel.sv
// ---------------------------------------------------------------------------
// apb_master_nsel : valid/ready command port to APB3/APB4 bridge, NUM_SLV slaves
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_nsel
  import apb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [ADDR_W-1:0]         cmd_addr_i,
  input  logic [DATA_W-1:0]         cmd_wdata_i,
  input  logic [DATA_W/8-1:0]       cmd_strb_i,
  output logic                      rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [1:0]                rsp_err_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [NUM_SLV-1:0]        psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [DATA_W-1:0]         pwdata_o,
  output logic [DATA_W/8-1:0]       pstrb_o,
  input  logic [NUM_SLV-1:0]        pready_i,
  input  logic [NUM_SLV*DATA_W-1:0] prdata_i,
  input  logic [NUM_SLV-1:0]        pslverr_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETUP  = SETUP;
  localparam logic [1:0] ST_ACCESS = ACCESS;
  localparam logic [1:0] ST_RESP   = RESP;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [STRB_W-1:0]  strb_q;
  logic               write_q;
  logic [NUM_SLV-1:0] sel_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [1:0]         err_q;
  logic [CNT_W-1:0]   cnt;

  logic [NUM_SLV-1:0] dec_sel;
  logic               dec_err;
  logic               sel_ready;
  logic               sel_err;
  logic [DATA_W-1:0]  sel_rdata;
  logic               active;
  logic               in_resp;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NUM_SLV (NUM_SLV)
  ) u_decode (
    .addr    (cmd_addr_i),
    .sel     (dec_sel),
    .dec_err (dec_err)
  );

  // AND-OR mux on the latched one-hot select: unselected slaves contribute nothing.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      sel_ready = sel_ready | (pready_i[k]  & sel_q[k]);
      sel_err   = sel_err   | (pslverr_i[k] & sel_q[k]);
      sel_rdata = sel_rdata | (prdata_i[k*DATA_W +: DATA_W] & {DATA_W{sel_q[k]}});
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_OKAY;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
            strb_q  <= cmd_strb_i;
            write_q <= cmd_write_i;
            sel_q   <= dec_sel;
            rdata_q <= '0;
            cnt     <= '0;
            if (dec_err) begin
              err_q <= ERR_DEC;
              state <= ST_RESP;
            end else begin
              err_q <= ERR_OKAY;
              state <= ST_SETUP;
            end
          end
        end
        ST_SETUP: begin
          state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // A ready in the final allowed cycle beats the timeout.
          if (sel_ready) begin
            rdata_q <= (write_q || sel_err) ? '0 : sel_rdata;
            err_q   <= sel_err ? ERR_SLV : ERR_OKAY;
            state   <= ST_RESP;
          end else if (TIMEOUT > 0) begin
            if (cnt == CNT_LAST) begin
              rdata_q <= '0;
              err_q   <= ERR_TIMEOUT;
              state   <= ST_RESP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign active  = (state == ST_SETUP) || (state == ST_ACCESS);
  assign in_resp = (state == ST_RESP);

  assign cmd_ready_o = (state == ST_IDLE);
  assign psel_o      = active ? sel_q : '0;
  assign penable_o   = (state == ST_ACCESS);
  assign pwrite_o    = active & write_q;
  assign paddr_o     = addr_q;
  assign pwdata_o    = wdata_q;
  assign pstrb_o     = (active && write_q) ? strb_q : '0;
  assign rsp_valid_o = in_resp;
  assign rsp_rdata_o = in_resp ? rdata_q : '0;
  assign rsp_err_o   = in_resp ? err_q : 2'b00;

endmodule

`default_nettype wire
